// File: rtl/sdram_burst_arbiter_if.sv
// Burst-command bus between the client requesters, the arbiter and the SDRAM controller.
// The arbiter connects through the slave modport; requesters and controller use master.
interface sdram_burst_arbiter_if #(
  parameter int NPORT = 4,
  parameter int ASIZE = 23,
  parameter int LSIZE = 9
);
  logic [NPORT-1:0]       REQ;
  logic [NPORT-1:0]       REQ_WR;
  logic [NPORT*ASIZE-1:0] REQ_ADDR;
  logic [NPORT*LSIZE-1:0] REQ_LEN;
  logic [NPORT-1:0]       GNT;
  logic [NPORT-1:0]       DONE;
  logic                   ERR;
  logic                   CMD_VALID;
  logic                   CMD_WR;
  logic [ASIZE-1:0]       CMD_ADDR;
  logic [LSIZE-1:0]       CMD_LEN;
  logic                   CMD_ACK;
  logic                   CMD_DONE;
  logic                   BUSY;

  modport slave (
    input  REQ, REQ_WR, REQ_ADDR, REQ_LEN, CMD_ACK, CMD_DONE,
    output GNT, DONE, ERR, CMD_VALID, CMD_WR, CMD_ADDR, CMD_LEN, BUSY
  );

  modport master (
    output REQ, REQ_WR, REQ_ADDR, REQ_LEN, CMD_ACK, CMD_DONE,
    input  GNT, DONE, ERR, CMD_VALID, CMD_WR, CMD_ADDR, CMD_LEN, BUSY
  );
endinterface

// File: rtl/sdram_burst_arbiter.sv
// Round-robin arbiter sharing the SDRAM controller burst-command port among NPORT
// requesters, with a watchdog that aborts a grant whose burst never completes.
module sdram_burst_arbiter #(
  parameter int NPORT   = 4,
  parameter int ASIZE   = 23,
  parameter int LSIZE   = 9,
  parameter int TIMEOUT = 1023
) (
  input logic                 CLK,
  input logic                 RESET_N,
  sdram_burst_arbiter_if.slave bus
);
  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0]    LAST_RST = PW'(NPORT - 1);
  localparam logic [CW-1:0]    WD_MAX   = CW'(TIMEOUT);
  localparam logic [NPORT-1:0] ONE_HOT  = {{(NPORT-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t           state_r;
  logic [PW-1:0]    last_r;
  logic [PW-1:0]    port_r;
  logic [CW-1:0]    wd_cnt_r;
  logic [NPORT-1:0] gnt_r;
  logic [NPORT-1:0] done_r;
  logic             err_r;
  logic             cmd_valid_r;
  logic             cmd_wr_r;
  logic [ASIZE-1:0] cmd_addr_r;
  logic [LSIZE-1:0] cmd_len_r;
  logic             busy_r;

  logic [ASIZE-1:0] req_addr_a [NPORT];
  logic [LSIZE-1:0] req_len_a  [NPORT];
  logic [NPORT-1:0] elig_s;
  logic             found_s;
  logic [PW-1:0]    pick_s;
  logic [PW-1:0]    idx_s;
  int               idx_i;

  for (genvar g = 0; g < NPORT; g++) begin : g_unpack
    assign req_addr_a[g] = bus.REQ_ADDR[g*ASIZE +: ASIZE];
    assign req_len_a[g]  = bus.REQ_LEN[g*LSIZE +: LSIZE];
    assign elig_s[g]     = bus.REQ[g] & (req_len_a[g] != {LSIZE{1'b0}});
  end

  // Round-robin search: first eligible port from last+1 upward, wrapping, ending at last.
  always_comb begin
    found_s = 1'b0;
    pick_s  = {PW{1'b0}};
    idx_i   = 0;
    idx_s   = {PW{1'b0}};
    for (int k = 1; k <= NPORT; k++) begin
      idx_i = int'(last_r) + k;
      idx_i = (idx_i >= NPORT) ? (idx_i - NPORT) : idx_i;
      idx_s = PW'(idx_i);
      if (!found_s && elig_s[idx_s]) begin
        found_s = 1'b1;
        pick_s  = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Grant FSM: latch the winner, issue the command, wait for completion or watchdog abort.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r     <= ST_IDLE;
      last_r      <= LAST_RST;
      port_r      <= {PW{1'b0}};
      wd_cnt_r    <= {CW{1'b0}};
      gnt_r       <= {NPORT{1'b0}};
      done_r      <= {NPORT{1'b0}};
      err_r       <= 1'b0;
      cmd_valid_r <= 1'b0;
      cmd_wr_r    <= 1'b0;
      cmd_addr_r  <= {ASIZE{1'b0}};
      cmd_len_r   <= {LSIZE{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      done_r <= {NPORT{1'b0}};
      err_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            state_r     <= ST_ISSUE;
            port_r      <= pick_s;
            gnt_r       <= ONE_HOT << pick_s;
            cmd_valid_r <= 1'b1;
            cmd_wr_r    <= bus.REQ_WR[pick_s];
            cmd_addr_r  <= req_addr_a[pick_s];
            cmd_len_r   <= req_len_a[pick_s];
            busy_r      <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (bus.CMD_ACK) begin
            cmd_valid_r <= 1'b0;
            wd_cnt_r    <= {CW{1'b0}};
            // Ack and done together: the burst is already over, skip WAIT.
            if (bus.CMD_DONE) begin
              state_r <= ST_IDLE;
              done_r  <= ONE_HOT << port_r;
              gnt_r   <= {NPORT{1'b0}};
              last_r  <= port_r;
              busy_r  <= 1'b0;
            end else begin
              state_r <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (bus.CMD_DONE) begin
            state_r <= ST_IDLE;
            done_r  <= ONE_HOT << port_r;
            gnt_r   <= {NPORT{1'b0}};
            last_r  <= port_r;
            busy_r  <= 1'b0;
          end else if (wd_cnt_r == WD_MAX) begin
            state_r <= ST_IDLE;
            err_r   <= 1'b1;
            gnt_r   <= {NPORT{1'b0}};
            last_r  <= port_r;
            busy_r  <= 1'b0;
          end else begin
            wd_cnt_r <= wd_cnt_r + CW'(1);
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          gnt_r       <= {NPORT{1'b0}};
          cmd_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.GNT       = gnt_r;
  assign bus.DONE      = done_r;
  assign bus.ERR       = err_r;
  assign bus.CMD_VALID = cmd_valid_r;
  assign bus.CMD_WR    = cmd_wr_r;
  assign bus.CMD_ADDR  = cmd_addr_r;
  assign bus.CMD_LEN   = cmd_len_r;
  assign bus.BUSY      = busy_r;
endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Self-checking bench for sdram_burst_arbiter: expected grants and completions are
// queued as stimulus is driven and popped by a monitor when the DUT produces them.
module tb_sdram_burst_arbiter;
  localparam int NPORT   = 4;
  localparam int ASIZE   = 23;
  localparam int LSIZE   = 9;
  localparam int TIMEOUT = 1023;
  localparam int MAXW    = 50;
  localparam int AW      = NPORT*ASIZE;
  localparam int LW      = NPORT*LSIZE;

  logic CLK = 1'b0;
  logic RESET_N;
  always #5 CLK = ~CLK;

  sdram_burst_arbiter_if #(.NPORT(NPORT), .ASIZE(ASIZE), .LSIZE(LSIZE)) bus ();

  sdram_burst_arbiter #(
    .NPORT(NPORT), .ASIZE(ASIZE), .LSIZE(LSIZE), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .bus(bus)
  );

  typedef struct {
    int               port;
    logic             wr;
    logic [ASIZE-1:0] addr;
    logic [LSIZE-1:0] len;
  } gnt_exp_t;

  typedef struct {
    int   port;
    logic err;
  } cpl_exp_t;

  gnt_exp_t gnt_q[$];
  cpl_exp_t cpl_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic [NPORT-1:0] prev_gnt = 4'b0000;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_port(input int p, input logic req, input logic wr,
                          input logic [ASIZE-1:0] addr, input logic [LSIZE-1:0] len);
    logic [NPORT-1:0] oh;
    logic [AW-1:0]    am;
    logic [LW-1:0]    lm;
    oh = NPORT'(1) << p;
    am = AW'({ASIZE{1'b1}}) << (p*ASIZE);
    lm = LW'({LSIZE{1'b1}}) << (p*LSIZE);
    bus.REQ      = req ? (bus.REQ | oh) : (bus.REQ & ~oh);
    bus.REQ_WR   = wr ? (bus.REQ_WR | oh) : (bus.REQ_WR & ~oh);
    bus.REQ_ADDR = (bus.REQ_ADDR & ~am) | (AW'(addr) << (p*ASIZE));
    bus.REQ_LEN  = (bus.REQ_LEN & ~lm) | (LW'(len) << (p*LSIZE));
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    do begin
      cycle();
      n++;
      @(negedge CLK);
    end while (bus.GNT == 4'b0000 && n < MAXW);
    check("grant_arrived", 64'(bus.GNT != 4'b0000), 64'(1));
  endtask

  task automatic send_ack();
    bus.CMD_ACK = 1'b1;
    cycle();
    bus.CMD_ACK = 1'b0;
    @(negedge CLK);
    check("ack_valid_low", 64'(bus.CMD_VALID), 64'(0));
    check("ack_busy", 64'(bus.BUSY), 64'(1));
  endtask

  task automatic send_done(input int p);
    cpl_q.push_back('{p, 1'b0});
    bus.CMD_DONE = 1'b1;
    cycle();
    bus.CMD_DONE = 1'b0;
    @(negedge CLK);
    check("done_pulse", 64'(bus.DONE), 64'(NPORT'(1) << p));
    check("done_gnt_low", 64'(bus.GNT), 64'(0));
    check("done_busy_low", 64'(bus.BUSY), 64'(0));
  endtask

  // Scoreboard monitor: pops expected grants/completions as the DUT produces them.
  always @(negedge CLK) begin
    gnt_exp_t ge;
    cpl_exp_t ce;
    if (RESET_N === 1'b1) begin
      if (bus.GNT != 4'b0000 && prev_gnt == 4'b0000) begin
        if (gnt_q.size() == 0) begin
          check("unexpected_grant", 64'(bus.GNT), 64'(0));
        end else begin
          ge = gnt_q.pop_front();
          check("sb_gnt", 64'(bus.GNT), 64'(NPORT'(1) << ge.port));
          check("sb_valid", 64'(bus.CMD_VALID), 64'(1));
          check("sb_wr", 64'(bus.CMD_WR), 64'(ge.wr));
          check("sb_addr", 64'(bus.CMD_ADDR), 64'(ge.addr));
          check("sb_len", 64'(bus.CMD_LEN), 64'(ge.len));
        end
      end
      if (bus.DONE != 4'b0000 || bus.ERR) begin
        if (cpl_q.size() == 0) begin
          check("unexpected_cpl", 64'({bus.ERR, bus.DONE}), 64'(0));
        end else begin
          ce = cpl_q.pop_front();
          check("sb_done", 64'(bus.DONE), ce.err ? 64'(0) : 64'(NPORT'(1) << ce.port));
          check("sb_err", 64'(bus.ERR), 64'(ce.err));
        end
      end
    end
    prev_gnt = bus.GNT;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    RESET_N      = 1'b0;
    bus.REQ      = '0;
    bus.REQ_WR   = '0;
    bus.REQ_ADDR = '0;
    bus.REQ_LEN  = '0;
    bus.CMD_ACK  = 1'b0;
    bus.CMD_DONE = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_gnt", 64'(bus.GNT), 64'(0));
    check("rst_flags", 64'({bus.DONE, bus.ERR, bus.CMD_VALID, bus.BUSY, bus.CMD_WR}), 64'(0));
    check("rst_addr_len", 64'({bus.CMD_ADDR, bus.CMD_LEN}), 64'(0));
    cycle();
    RESET_N = 1'b1;
    cycle();
    @(negedge CLK);
    check("idle_busy", 64'(bus.BUSY), 64'(0));

    // All ports held requesting: strict rotation with one IDLE cycle between grants.
    for (int p = 0; p < NPORT; p++) begin
      set_port(p, 1'b1, p[0], ASIZE'(32'h1000 * (p + 1)), LSIZE'(p + 1));
    end
    for (int b = 0; b < 8; b++) begin
      gnt_q.push_back('{b % NPORT, (b % NPORT) % 2 == 1, ASIZE'(32'h1000 * ((b % NPORT) + 1)), LSIZE'((b % NPORT) + 1)});
    end
    for (int b = 0; b < 8; b++) begin
      wait_grant(n);
      check("rr_gap", 64'(n), 64'(1));
      check("rr_gnt", 64'(bus.GNT), 64'(NPORT'(1) << (b % NPORT)));
      if (b == 7) bus.REQ = 4'b0000;
      send_ack();
      repeat (2) cycle();
      send_done(b % NPORT);
    end

    // Single request on port 2 with a long burst.
    gnt_q.push_back('{2, 1'b1, 23'h000100, 9'd256});
    set_port(2, 1'b1, 1'b1, 23'h000100, 9'd256);
    wait_grant(n);
    check("t1_latency", 64'(n), 64'(1));
    check("t1_gnt", 64'(bus.GNT), 64'(4'b0100));
    check("t1_valid_busy", 64'({bus.CMD_VALID, bus.BUSY}), 64'(2'b11));
    set_port(2, 1'b0, 1'b1, 23'h000100, 9'd256);
    repeat (2) cycle();
    send_ack();
    repeat (299) cycle();
    @(negedge CLK);
    check("t1_hold", 64'({bus.GNT, bus.CMD_ADDR, bus.CMD_LEN}), 64'({4'b0100, 23'h000100, 9'd256}));
    send_done(2);
    cycle();
    @(negedge CLK);
    check("t1_done_once", 64'(bus.DONE), 64'(0));

    // Zero-length port 0 must never win; port 1 is served instead.
    set_port(0, 1'b1, 1'b0, 23'h000777, 9'd0);
    gnt_q.push_back('{1, 1'b0, 23'h002000, 9'd8});
    set_port(1, 1'b1, 1'b0, 23'h002000, 9'd8);
    wait_grant(n);
    check("t3_gnt", 64'(bus.GNT), 64'(4'b0010));
    set_port(1, 1'b0, 1'b0, 23'h002000, 9'd8);
    send_ack();
    send_done(1);
    repeat (5) cycle();
    @(negedge CLK);
    check("t3_no_grant", 64'({bus.GNT, bus.BUSY}), 64'(0));
    set_port(0, 1'b0, 1'b0, 23'h000000, 9'd0);

    // Mid-burst input changes are ignored; stray CMD_DONE in ISSUE/IDLE is ignored.
    gnt_q.push_back('{1, 1'b0, 23'h03A5A5, 9'd16});
    set_port(1, 1'b1, 1'b0, 23'h03A5A5, 9'd16);
    wait_grant(n);
    bus.CMD_DONE = 1'b1;
    cycle();
    bus.CMD_DONE = 1'b0;
    @(negedge CLK);
    check("t4_done_in_issue", 64'({bus.CMD_VALID, bus.DONE}), 64'({1'b1, 4'b0000}));
    send_ack();
    set_port(1, 1'b0, 1'b1, 23'h7FFFFF, 9'd1);
    repeat (3) cycle();
    @(negedge CLK);
    check("t4_latched", 64'({bus.GNT, bus.CMD_WR, bus.CMD_ADDR, bus.CMD_LEN}),
          64'({4'b0010, 1'b0, 23'h03A5A5, 9'd16}));
    send_done(1);
    bus.CMD_DONE = 1'b1;
    cycle();
    bus.CMD_DONE = 1'b0;
    @(negedge CLK);
    check("t4_done_in_idle", 64'({bus.DONE, bus.BUSY}), 64'(0));

    // Simultaneous ACK and DONE in ISSUE: straight back to IDLE.
    gnt_q.push_back('{2, 1'b0, 23'h004444, 9'd2});
    set_port(2, 1'b1, 1'b0, 23'h004444, 9'd2);
    wait_grant(n);
    set_port(2, 1'b0, 1'b0, 23'h004444, 9'd2);
    cpl_q.push_back('{2, 1'b0});
    bus.CMD_ACK  = 1'b1;
    bus.CMD_DONE = 1'b1;
    cycle();
    bus.CMD_ACK  = 1'b0;
    bus.CMD_DONE = 1'b0;
    @(negedge CLK);
    check("t5_state", 64'({bus.CMD_VALID, bus.DONE, bus.GNT, bus.BUSY}),
          64'({1'b0, 4'b0100, 4'b0000, 1'b0}));

    // Watchdog: ACK without DONE gives ERR TIMEOUT+1 cycles after the ACK edge.
    gnt_q.push_back('{3, 1'b1, 23'h0ABCDE, 9'd511});
    set_port(3, 1'b1, 1'b1, 23'h0ABCDE, 9'd511);
    wait_grant(n);
    set_port(3, 1'b0, 1'b1, 23'h0ABCDE, 9'd511);
    cpl_q.push_back('{3, 1'b1});
    bus.CMD_ACK = 1'b1;
    cycle();
    bus.CMD_ACK = 1'b0;
    n = 0;
    @(negedge CLK);
    while (!bus.ERR && n < TIMEOUT + 20) begin
      cycle();
      n++;
      @(negedge CLK);
    end
    check("t6_err_latency", 64'(n), 64'(TIMEOUT + 1));
    check("t6_err_outputs", 64'({bus.DONE, bus.GNT, bus.BUSY}), 64'(0));
    cycle();
    @(negedge CLK);
    check("t6_err_once", 64'(bus.ERR), 64'(0));

    // Asynchronous reset in the middle of ISSUE.
    gnt_q.push_back('{0, 1'b0, 23'h000055, 9'd4});
    set_port(0, 1'b1, 1'b0, 23'h000055, 9'd4);
    wait_grant(n);
    check("t7_issue", 64'({bus.CMD_VALID, bus.BUSY}), 64'(2'b11));
    #2;
    RESET_N = 1'b0;
    #1;
    check("t7_async_gnt", 64'({bus.GNT, bus.DONE, bus.ERR, bus.CMD_VALID, bus.BUSY, bus.CMD_WR}), 64'(0));
    check("t7_async_cmd", 64'({bus.CMD_ADDR, bus.CMD_LEN}), 64'(0));
    bus.REQ = 4'b0000;
    cycle();
    RESET_N = 1'b1;
    cycle();
    @(negedge CLK);
    check("t7_idle_after", 64'({bus.GNT, bus.BUSY}), 64'(0));

    check("sb_gnt_left", 64'(gnt_q.size()), 64'(0));
    check("sb_cpl_left", 64'(cpl_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sdram_burst_arbiter.md
# sdram_burst_arbiter

Round-robin arbiter that shares the single burst-command port of the SDRAM controller among NPORT requesters (video write, video read, CPU, DMA). It latches one requester's address, length and direction, issues a single burst command, waits for burst completion, then returns a one-cycle DONE to the winner. A watchdog aborts the grant if the controller never reports completion. It sits between the client FIFOs' auto read/write logic and the SDRAM controller command interface, all on the SDRAM-side CLK.

## Interface
- NPORT, 4, number of requesters (2..8)
- ASIZE, 23, SDRAM word address width
- LSIZE, 9, burst length width (words)
- TIMEOUT, 1023, max CLK cycles from CMD_ACK to CMD_DONE before abort
- CLK  in  1  controller clock
- RESET_N  in  1  asynchronous, active-low reset
- REQ  in  NPORT  per-port burst request (level)
- REQ_WR  in  NPORT  per-port direction, 1=write, 0=read
- REQ_ADDR  in  NPORT*ASIZE  per-port start address, port i at [i*ASIZE +: ASIZE]
- REQ_LEN  in  NPORT*LSIZE  per-port burst length, port i at [i*LSIZE +: LSIZE]
- GNT  out  NPORT  one-hot grant, held for the whole burst
- DONE  out  NPORT  one-cycle completion pulse to the granted port
- ERR  out  1  one-cycle pulse on watchdog abort
- CMD_VALID  out  1  burst command valid to controller
- CMD_WR  out  1  latched direction
- CMD_ADDR  out  ASIZE  latched start address
- CMD_LEN  out  LSIZE  latched length
- CMD_ACK  in  1  controller accepted the command (single-cycle)
- CMD_DONE  in  1  controller finished the burst (single-cycle)
- BUSY  out  1  high in any state other than IDLE

## Operation
- Eligible port i: REQ[i]=1 and REQ_LEN[i]!=0. Zero-length requests are never granted.
- Priority pointer `last` (log2 NPORT bits). Search order: last+1, last+2, ..., wrapping modulo NPORT, ending at last. Reset value of `last` is NPORT-1, so port 0 wins first.
- States:
  - IDLE: if any port is eligible, pick the first one in search order. Latch CMD_WR, CMD_ADDR and CMD_LEN from that port. Set GNT to one-hot and CMD_VALID=1, then go to ISSUE.
  - ISSUE: hold CMD_VALID and the latched fields. On CMD_ACK, clear CMD_VALID, clear the watchdog counter and go to WAIT.
  - WAIT: on CMD_DONE, pulse DONE[port], clear GNT, set last=port and go to IDLE. If the counter reaches TIMEOUT first, pulse ERR, clear GNT, set last=port and go to IDLE. DONE is not pulsed on a timeout.
- Latched fields stay stable from grant until return to IDLE. Input changes, including REQ deassertion, are ignored mid-burst and the burst runs to completion.
- CMD_DONE in IDLE or ISSUE is ignored. CMD_ACK and CMD_DONE in the same ISSUE cycle count as ack followed immediately by done: go straight to IDLE and pulse DONE.
- Watchdog counter width is ceil(log2(TIMEOUT+1)). It saturates and does not wrap.

## Timing
- Reset values: GNT=0, DONE=0, ERR=0, CMD_VALID=0, CMD_WR=0, CMD_ADDR=0, CMD_LEN=0, BUSY=0, state=IDLE.
- Reset mid-burst forces all of the above immediately, whatever the state.
- Latency: REQ sampled high in IDLE at edge N gives GNT and CMD_VALID high after edge N, both in the same cycle.
- CMD_ACK sampled at edge M gives CMD_VALID low after edge M.
- CMD_DONE sampled at edge K gives DONE high for exactly the cycle after edge K. GNT is low in that same cycle and BUSY=0.
- Re-arbitration happens at the edge after DONE, so each grant is separated by at least one IDLE cycle.
- A requester must drop REQ within the DONE cycle. If it does not, it is re-eligible, but it gets lowest priority.
- Timeout: ERR rises TIMEOUT+1 cycles after the CMD_ACK edge if no CMD_DONE arrives.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Single request: port 2, REQ_WR=1, addr 0x000100, len 256; ACK 3 cycles later, DONE 300 cycles later. Expect GNT=0100, CMD_ADDR=0x000100, CMD_LEN=256, DONE[2] pulsed once, BUSY falls in the same cycle.
- All four ports held requesting over 8 bursts. Expect grant order 0,1,2,3,0,1,2,3, with exactly one IDLE cycle between grants.
- Zero length: port 0 has REQ=1, len 0; port 1 has len 8. Expect only port 1 granted, and port 0 never granted.
- Mid-burst change: while port 1 is in WAIT, change its REQ_ADDR and drop REQ. Expect CMD_ADDR unchanged and DONE[1] still pulsed on CMD_DONE.
- Simultaneous ACK and DONE in ISSUE. Expect CMD_VALID low, DONE pulsed in the following cycle, and no WAIT state entered.
- Watchdog: TIMEOUT=15, CMD_ACK given, no CMD_DONE. Expect ERR at ACK+16 cycles, no DONE, GNT cleared. Then assert RESET_N low during a later ISSUE and expect all outputs zero asynchronously.
